databus_axi_read_bridge: RTL and testbench

Converts the unit-side databus read protocol into AXI4 read bursts; sits directly upstream of every memory-reading unit (VRead-class units) and supplies the `databus_ready`/`rdata`/`last` beats those units load into their ping-pong memories. One request (start address + length, held constant by the unit) becomes one AXI burst, or two when it crosses a 4 KB boundary. Per-beat flow control comes from the unit's `databus_valid`.

---
 rtl/databus_axi_read_bridge.sv | 110 +++++++++++
 tb/tb_databus_axi_read_bridge.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/databus_axi_read_bridge.sv
// databus_axi_read_bridge: turns a held databus read request into one or two AXI4 INCR read bursts split at 4 KB
module databus_axi_read_bridge #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  databus_valid_i,
  output logic                  databus_ready_o,
  input  logic [AXI_ADDR_W-1:0] databus_addr_i,
  input  logic [LEN_W-1:0]      databus_len_i,
  output logic [AXI_DATA_W-1:0] databus_rdata_o,
  output logic                  databus_last_o,
  output logic [AXI_ADDR_W-1:0] m_axi_araddr_o,
  output logic [7:0]            m_axi_arlen_o,
  output logic [2:0]            m_axi_arsize_o,
  output logic [1:0]            m_axi_arburst_o,
  output logic                  m_axi_arvalid_o,
  input  logic                  m_axi_arready_i,
  input  logic [AXI_DATA_W-1:0] m_axi_rdata_i,
  input  logic [1:0]            m_axi_rresp_i,
  input  logic                  m_axi_rlast_i,
  input  logic                  m_axi_rvalid_i,
  output logic                  m_axi_rready_o,
  output logic                  busy_o,
  output logic                  error_o
);
  localparam int OFF = $clog2(AXI_DATA_W / 8);
  localparam logic [AXI_ADDR_W-1:0] ALIGN = AXI_ADDR_W'((1 << OFF) - 1);
  localparam logic [AXI_ADDR_W-1:0] PAGE = AXI_ADDR_W'(4096);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t                state_q, state_d;
  logic [AXI_ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [8:0]            remaining_q, remaining_d;
  logic [8:0]            burst_beats_q, burst_beats_d;
  logic [8:0]            burst_cnt_q, burst_cnt_d;
  logic                  final_burst_q, final_burst_d;
  logic                  error_q, error_d;
  logic                  fire;
  function automatic logic [8:0] calc_beats(input logic [11:0] a, input logic [8:0] rem);
    logic [12:0] tb;
    tb = (13'd4096 - {1'b0, a}) >> OFF;
    return ({4'd0, rem} < tb) ? rem : tb[8:0];
  endfunction
  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    burst_beats_d = burst_beats_q;
    burst_cnt_d   = burst_cnt_q;
    final_burst_d = final_burst_q;
    error_d       = error_q;
    fire          = state_q == DATA && m_axi_rvalid_i && databus_valid_i;
    if (state_q == IDLE && databus_valid_i) begin
      cur_addr_d    = databus_addr_i & ~ALIGN;
      remaining_d   = 9'(databus_len_i) + 9'd1;
      burst_beats_d = calc_beats(cur_addr_d[11:0], remaining_d);
      state_d       = ADDR;
    end
    if (state_q == ADDR && m_axi_arready_i) begin
      remaining_d   = remaining_q - burst_beats_q;
      final_burst_d = remaining_d == 9'd0;
      burst_cnt_d   = '0;
      state_d       = DATA;
    end
    if (fire) begin
      burst_cnt_d = burst_cnt_q + 9'd1;
      if (m_axi_rresp_i != 2'b00) error_d = 1'b1;
      if (m_axi_rlast_i) begin
        if (burst_cnt_d != burst_beats_q) error_d = 1'b1;
        state_d = final_burst_q ? IDLE : ADDR;
        if (!final_burst_q) begin
          cur_addr_d    = {cur_addr_q[AXI_ADDR_W-1:12], 12'h000} + PAGE;
          burst_beats_d = calc_beats(12'h000, remaining_q);
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      burst_beats_q <= '0;
      burst_cnt_q   <= '0;
      final_burst_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      burst_beats_q <= burst_beats_d;
      burst_cnt_q   <= burst_cnt_d;
      final_burst_q <= final_burst_d;
      error_q       <= error_d;
    end
  end
  assign busy_o          = state_q != IDLE;
  assign error_o         = error_q;
  assign m_axi_arvalid_o = state_q == ADDR;
  assign m_axi_araddr_o  = cur_addr_q;
  assign m_axi_arlen_o   = state_q == ADDR ? 8'(burst_beats_q - 9'd1) : 8'd0;
  assign m_axi_arsize_o  = 3'(OFF);
  assign m_axi_arburst_o = 2'b01;
  assign m_axi_rready_o  = state_q == DATA && databus_valid_i;
  assign databus_ready_o = state_q == DATA && m_axi_rvalid_i;
  assign databus_rdata_o = state_q == DATA ? m_axi_rdata_i : '0;
  assign databus_last_o  = state_q == DATA && m_axi_rvalid_i && m_axi_rlast_i && final_burst_q;
endmodule

// File: tb/tb_databus_axi_read_bridge.sv
// tb_databus_axi_read_bridge: directed checks of bursts, stalls, 4 KB split, AR backpressure, errors and reset
module tb_databus_axi_read_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        databus_valid_i;
  logic        databus_ready_o;
  logic [31:0] databus_addr_i;
  logic [7:0]  databus_len_i;
  logic [31:0] databus_rdata_o;
  logic        databus_last_o;
  logic [31:0] m_axi_araddr_o;
  logic [7:0]  m_axi_arlen_o;
  logic [2:0]  m_axi_arsize_o;
  logic [1:0]  m_axi_arburst_o;
  logic        m_axi_arvalid_o;
  logic        m_axi_arready_i;
  logic [31:0] m_axi_rdata_i;
  logic [1:0]  m_axi_rresp_i;
  logic        m_axi_rlast_i;
  logic        m_axi_rvalid_i;
  logic        m_axi_rready_o;
  logic        busy_o;
  logic        error_o;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  databus_axi_read_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .databus_valid_i(databus_valid_i), .databus_ready_o(databus_ready_o),
    .databus_addr_i(databus_addr_i), .databus_len_i(databus_len_i),
    .databus_rdata_o(databus_rdata_o), .databus_last_o(databus_last_o),
    .m_axi_araddr_o(m_axi_araddr_o), .m_axi_arlen_o(m_axi_arlen_o),
    .m_axi_arsize_o(m_axi_arsize_o), .m_axi_arburst_o(m_axi_arburst_o),
    .m_axi_arvalid_o(m_axi_arvalid_o), .m_axi_arready_i(m_axi_arready_i),
    .m_axi_rdata_i(m_axi_rdata_i), .m_axi_rresp_i(m_axi_rresp_i),
    .m_axi_rlast_i(m_axi_rlast_i), .m_axi_rvalid_i(m_axi_rvalid_i),
    .m_axi_rready_o(m_axi_rready_o), .busy_o(busy_o), .error_o(error_o)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic req(input logic [31:0] a, input logic [7:0] l);
    databus_addr_i  = a;
    databus_len_i   = l;
    databus_valid_i = 1'b1;
    tick();
  endtask
  task automatic chk_ar(input string tag, input logic [31:0] a, input logic [7:0] l);
    #1;
    chk({tag, "_arvalid"}, m_axi_arvalid_o, 1'b1);
    chk({tag, "_araddr"}, m_axi_araddr_o, a);
    chk({tag, "_arlen"}, m_axi_arlen_o, l);
    chk({tag, "_rready"}, m_axi_rready_o, 1'b0);
    tick();
  endtask
  task automatic beat(input string tag, input logic [31:0] d, input logic l, input logic [1:0] r, input logic exp_last);
    databus_valid_i = 1'b1;
    m_axi_rvalid_i  = 1'b1;
    m_axi_rdata_i   = d;
    m_axi_rlast_i   = l;
    m_axi_rresp_i   = r;
    #1;
    chk({tag, "_ready"}, databus_ready_o, 1'b1);
    chk({tag, "_rready"}, m_axi_rready_o, 1'b1);
    chk({tag, "_rdata"}, databus_rdata_o, d);
    chk({tag, "_last"}, databus_last_o, exp_last);
    tick();
    m_axi_rvalid_i = 1'b0;
    m_axi_rlast_i  = 1'b0;
    m_axi_rresp_i  = 2'b00;
  endtask
  task automatic done(input string tag, input logic exp_err);
    databus_valid_i = 1'b0;
    #1;
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_arvalid"}, m_axi_arvalid_o, 1'b0);
    chk({tag, "_error"}, error_o, exp_err);
    tick();
  endtask
  initial begin
    rst_n = 1'b0;
    databus_valid_i = 1'b0;
    databus_addr_i = '0;
    databus_len_i = '0;
    m_axi_arready_i = 1'b1;
    m_axi_rdata_i = '0;
    m_axi_rresp_i = 2'b00;
    m_axi_rlast_i = 1'b0;
    m_axi_rvalid_i = 1'b0;
    tick();
    tick();
    chk("rst_arvalid", m_axi_arvalid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_error", error_o, 1'b0);
    chk("rst_arsize", m_axi_arsize_o, 3'd2);
    chk("rst_arburst", m_axi_arburst_o, 2'b01);
    chk("rst_arlen", m_axi_arlen_o, 8'd0);
    chk("rst_ready", databus_ready_o, 1'b0);
    rst_n = 1'b1;
    tick();
    req(32'h1000, 8'd3);
    chk("basic_busy", busy_o, 1'b1);
    chk_ar("basic_ar", 32'h1000, 8'd3);
    #1;
    chk("basic_idle_ready", databus_ready_o, 1'b0);
    chk("basic_data_rready", m_axi_rready_o, 1'b1);
    for (int i = 0; i < 4; i++) beat("basic_b", 32'hA0 + i, i == 3, 2'b00, i == 3);
    done("basic_end", 1'b0);
    req(32'h1000, 8'd3);
    chk_ar("stall_ar", 32'h1000, 8'd3);
    beat("stall_b1", 32'hB1, 1'b0, 2'b00, 1'b0);
    beat("stall_b2", 32'hB2, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      databus_valid_i = 1'b0;
      m_axi_rvalid_i  = 1'b1;
      m_axi_rdata_i   = 32'hB3;
      #1;
      chk("stall_rready", m_axi_rready_o, 1'b0);
      chk("stall_busy", busy_o, 1'b1);
      tick();
    end
    beat("stall_b3", 32'hB3, 1'b0, 2'b00, 1'b0);
    beat("stall_b4", 32'hB4, 1'b1, 2'b00, 1'b1);
    done("stall_end", 1'b0);
    req(32'h0FF8, 8'd3);
    chk_ar("split_ar0", 32'h0FF8, 8'd1);
    beat("split_b1", 32'hC1, 1'b0, 2'b00, 1'b0);
    beat("split_b2", 32'hC2, 1'b1, 2'b00, 1'b0);
    chk_ar("split_ar1", 32'h1000, 8'd1);
    beat("split_b3", 32'hC3, 1'b0, 2'b00, 1'b0);
    beat("split_b4", 32'hC4, 1'b1, 2'b00, 1'b1);
    done("split_end", 1'b0);
    m_axi_arready_i = 1'b0;
    req(32'h2000, 8'd1);
    for (int i = 0; i < 6; i++) begin
      m_axi_arready_i = i == 5;
      m_axi_rvalid_i  = 1'b1;
      m_axi_rdata_i   = 32'hEE;
      #1;
      chk("bp_arvalid", m_axi_arvalid_o, 1'b1);
      chk("bp_araddr", m_axi_araddr_o, 32'h2000);
      chk("bp_arlen", m_axi_arlen_o, 8'd1);
      chk("bp_rready", m_axi_rready_o, 1'b0);
      chk("bp_ready", databus_ready_o, 1'b0);
      tick();
    end
    m_axi_rvalid_i = 1'b0;
    beat("bp_b1", 32'hD1, 1'b0, 2'b00, 1'b0);
    beat("bp_b2", 32'hD2, 1'b1, 2'b00, 1'b1);
    done("bp_end", 1'b0);
    req(32'h3000, 8'd3);
    chk_ar("slv_ar", 32'h3000, 8'd3);
    beat("slv_b1", 32'hE1, 1'b0, 2'b00, 1'b0);
    chk("slv_err_before", error_o, 1'b0);
    beat("slv_b2", 32'hE2, 1'b0, 2'b10, 1'b0);
    chk("slv_err_next", error_o, 1'b1);
    beat("slv_b3", 32'hE3, 1'b0, 2'b00, 1'b0);
    beat("slv_b4", 32'hE4, 1'b1, 2'b00, 1'b1);
    done("slv_end", 1'b1);
    req(32'h6000, 8'd3);
    chk_ar("rst_mid_ar", 32'h6000, 8'd3);
    beat("rst_mid_b1", 32'hF1, 1'b0, 2'b00, 1'b0);
    m_axi_rvalid_i = 1'b1;
    m_axi_rdata_i  = 32'hDEAD;
    rst_n = 1'b0;
    tick();
    #1;
    chk("rst_mid_arvalid", m_axi_arvalid_o, 1'b0);
    chk("rst_mid_rready", m_axi_rready_o, 1'b0);
    chk("rst_mid_ready", databus_ready_o, 1'b0);
    chk("rst_mid_rdata", databus_rdata_o, 32'h0);
    chk("rst_mid_last", databus_last_o, 1'b0);
    chk("rst_mid_busy", busy_o, 1'b0);
    chk("rst_mid_error", error_o, 1'b0);
    chk("rst_mid_araddr", m_axi_araddr_o, 32'h0);
    chk("rst_mid_arlen", m_axi_arlen_o, 8'd0);
    rst_n = 1'b1;
    m_axi_rvalid_i = 1'b0;
    databus_valid_i = 1'b0;
    tick();
    m_axi_arready_i = 1'b1;
    req(32'h0046, 8'd0);
    chk_ar("post_rst_ar", 32'h0044, 8'd0);
    beat("post_rst_b1", 32'h77, 1'b1, 2'b00, 1'b1);
    done("post_rst_end", 1'b0);
    req(32'h5000, 8'd3);
    chk_ar("early_ar", 32'h5000, 8'd3);
    beat("early_b1", 32'h91, 1'b0, 2'b00, 1'b0);
    beat("early_b2", 32'h92, 1'b0, 2'b00, 1'b0);
    chk("early_err_before", error_o, 1'b0);
    beat("early_b3", 32'h93, 1'b1, 2'b00, 1'b1);
    done("early_end", 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
